// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back cache with its own controller FSM between a CPU port
// and a fixed-latency, stallable main memory; multi-word lines filled with pipelined reads.
module wb_cache_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WSEL_W      = 2,
  parameter int INDEX_W     = 8,
  parameter int MEM_LAT     = 2,
  parameter int WRITE_ALLOC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  output logic [ADDR_W-1:0] mAddr,
  output logic [DATA_W-1:0] mDataIn,
  output logic              mWr,
  output logic              mRd,
  input  logic [DATA_W-1:0] mDataOut,
  input  logic              mStall
);
  localparam int WORDS = 2**WSEL_W;
  localparam int LINES = 2**INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - WSEL_W - 1;
  localparam logic [WSEL_W:0] LAST = (WSEL_W+1)'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, COMPARE, ERR, WB, FILL, FINISH, WRNA} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES][WORDS];
  logic [LINES-1:0]  valid_arr, dirty_arr;

  logic [TAG_W-1:0]   a_tag;
  logic [INDEX_W-1:0] idx;
  logic [WSEL_W-1:0]  wsel;
  logic               wr_q, hit, issue, ret;
  logic [WSEL_W:0]    cnt, rcnt;
  logic [WSEL_W:0]    ret_pipe [MEM_LAT];
  logic [WSEL_W-1:0]  ret_word;

  assign a_tag    = Addr[ADDR_W-1 -: TAG_W];
  assign idx      = Addr[INDEX_W+WSEL_W -: INDEX_W];
  assign wsel     = Addr[WSEL_W:1];
  assign hit      = valid_arr[idx] & (tag_arr[idx] == a_tag);
  assign issue    = mRd & ~mStall;
  // Each accepted read carries its word number down a MEM_LAT-deep pipe; the tail marks data on mDataOut.
  assign ret      = (state == FILL) & ret_pipe[MEM_LAT-1][WSEL_W];
  assign ret_word = ret_pipe[MEM_LAT-1][WSEL_W-1:0];
  assign Stall    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Rd | Wr) state_nxt = ((Rd & Wr) | Addr[0]) ? ERR : COMPARE;
      COMPARE: begin
        if (hit)                                      state_nxt = IDLE;
        else if (valid_arr[idx] & dirty_arr[idx])     state_nxt = WB;
        else if (wr_q && WRITE_ALLOC == 0)            state_nxt = WRNA;
        else                                          state_nxt = FILL;
      end
      ERR:     state_nxt = IDLE;
      WB:      if (!mStall && cnt == LAST) state_nxt = (wr_q && WRITE_ALLOC == 0) ? WRNA : FILL;
      FILL:    if (ret && rcnt == LAST) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      WRNA:    if (!mStall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mRd     = 1'b0;
    mWr     = 1'b0;
    mAddr   = Addr;
    mDataIn = DataIn;
    case (state)
      WB: begin
        mWr     = 1'b1;
        mAddr   = {tag_arr[idx], idx, cnt[WSEL_W-1:0], 1'b0};
        mDataIn = data_arr[idx][cnt[WSEL_W-1:0]];
      end
      FILL: begin
        mRd   = ~cnt[WSEL_W];
        mAddr = {a_tag, idx, cnt[WSEL_W-1:0], 1'b0};
      end
      WRNA:    mWr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q      <= 1'b0;
      cnt       <= '0;
      rcnt      <= '0;
      valid_arr <= '0;
      dirty_arr <= '0;
      Done      <= 1'b0;
      CacheHit  <= 1'b0;
      err       <= 1'b0;
      DataOut   <= '0;
      for (int i = 0; i < MEM_LAT; i++) ret_pipe[i] <= '0;
    end else begin
      if (state == IDLE) wr_q <= Wr;
      // Counters restart on every state change so WB and FILL both begin at word 0.
      if (state_nxt != state)                 cnt <= '0;
      else if ((state == WB && !mStall) || issue) cnt <= cnt + 1'b1;
      if (state_nxt != state) rcnt <= '0;
      else if (ret)           rcnt <= rcnt + 1'b1;
      ret_pipe[0] <= {issue, cnt[WSEL_W-1:0]};
      for (int i = 1; i < MEM_LAT; i++) ret_pipe[i] <= ret_pipe[i-1];
      if (state == COMPARE && hit && wr_q) dirty_arr[idx] <= 1'b1;
      if (state == WB && state_nxt != WB)  dirty_arr[idx] <= 1'b0;
      if (state == FINISH) begin
        valid_arr[idx] <= 1'b1;
        dirty_arr[idx] <= wr_q;
      end
      Done     <= (state == ERR) | (state == FINISH) | ((state == COMPARE) & hit) |
                  ((state == WRNA) & ~mStall);
      CacheHit <= (state == COMPARE) & hit;
      err      <= (state == ERR);
      DataOut  <= '0;
      if (state == COMPARE && hit && !wr_q) DataOut <= data_arr[idx][wsel];
      else if (state == FINISH)             DataOut <= wr_q ? DataIn : data_arr[idx][wsel];
    end
  end

  always_ff @(posedge clk) begin
    if (ret) data_arr[idx][ret_word] <= mDataOut;
    if (state == COMPARE && hit && wr_q) data_arr[idx][wsel] <= DataIn;
    if (state == FINISH) begin
      tag_arr[idx] <= a_tag;
      if (wr_q) data_arr[idx][wsel] <= DataIn;
    end
  end
endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Directed bench for wb_cache_ctrl: one write-allocate instance and one write-no-allocate
// instance share a latency-2 stallable memory model; sel routes the CPU port between them.
module tb_wb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] Addr = '0, DataIn = '0, mDataOut;
  logic Rd = 1'b0, Wr = 1'b0, mStall = 1'b0, sel = 1'b0;
  logic a_rd, a_wr, b_rd, b_wr;
  logic [15:0] a_dout, b_dout, a_maddr, b_maddr, a_mdin, b_mdin;
  logic a_done, b_done, a_stall, b_stall, a_hit, b_hit, a_err, b_err;
  logic a_mwr, b_mwr, a_mrd, b_mrd;
  logic [15:0] DataOut, mAddr, mDataIn;
  logic Done, Stall, CacheHit, err, mRd, mWr;

  assign a_rd = Rd & ~sel;  assign a_wr = Wr & ~sel;
  assign b_rd = Rd & sel;   assign b_wr = Wr & sel;
  assign DataOut  = sel ? b_dout  : a_dout;
  assign mAddr    = sel ? b_maddr : a_maddr;
  assign mDataIn  = sel ? b_mdin  : a_mdin;
  assign Done     = sel ? b_done  : a_done;
  assign Stall    = sel ? b_stall : a_stall;
  assign CacheHit = sel ? b_hit   : a_hit;
  assign err      = sel ? b_err   : a_err;
  assign mRd      = sel ? b_mrd   : a_mrd;
  assign mWr      = sel ? b_mwr   : a_mwr;

  wb_cache_ctrl #(.WRITE_ALLOC(1)) dut_a (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(a_rd), .Wr(a_wr),
    .DataOut(a_dout), .Done(a_done), .Stall(a_stall), .CacheHit(a_hit), .err(a_err),
    .mAddr(a_maddr), .mDataIn(a_mdin), .mWr(a_mwr), .mRd(a_mrd),
    .mDataOut(mDataOut), .mStall(mStall));

  wb_cache_ctrl #(.WRITE_ALLOC(0)) dut_b (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(b_rd), .Wr(b_wr),
    .DataOut(b_dout), .Done(b_done), .Stall(b_stall), .CacheHit(b_hit), .err(b_err),
    .mAddr(b_maddr), .mDataIn(b_mdin), .mWr(b_mwr), .mRd(b_mrd),
    .mDataOut(mDataOut), .mStall(mStall));

  // Memory model: word = (byte address >> 1) ^ 0xC3A0 until written; read data two cycles after acceptance.
  logic [15:0] mem [32768];
  logic [15:0] lat1, lat2;
  logic [15:0] rd_q[$], wa_q[$], wd_q[$];
  assign mDataOut = lat2;
  always @(posedge clk) begin
    if (mWr && !mStall) begin
      mem[mAddr[15:1]] <= mDataIn;
      wa_q.push_back(mAddr);
      wd_q.push_back(mDataIn);
    end
    if (mRd && !mStall) rd_q.push_back(mAddr);
    lat1 <= (mRd && !mStall) ? mem[mAddr[15:1]] : 16'hDEAD;
    lat2 <= lat1;
  end

  int tests = 0;
  int fails = 0;

  task automatic clr();
    rd_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  // Presents a request at the current negedge and returns at the negedge of the Done cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int st_at, input int st_len, input int rst_at,
                        output int lat, output logic [15:0] dout, output logic h, output logic er,
                        output int hold_bad);
    logic [15:0] held;
    int n;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    n = 0; lat = -1; dout = '0; h = 1'b0; er = 1'b0; hold_bad = 0; held = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n++;
      Rd = 1'b0; Wr = 1'b0;
      if (n == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      if (st_len > 0 && n > st_at && n <= st_at + st_len && (!mRd || mAddr !== held)) hold_bad++;
      if (n == st_at) begin held = mAddr; mStall = 1'b1; end
      if (n == st_at + st_len) mStall = 1'b0;
      if (Done) begin lat = n; dout = DataOut; h = CacheHit; er = err; break; end
      if (n >= 100) begin
        tests++; fails++;
        $display("FAIL timeout: no Done after %0d cycles, addr %h", n, a);
        break;
      end
    end
  endtask

  int lat, hb;
  logic [15:0] dout;
  logic h, er;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({Done, Stall, CacheHit, err, mRd, mWr} !== 6'b0 || DataOut !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %b/%h expected 000000/0000",
               {Done, Stall, CacheHit, err, mRd, mWr}, DataOut);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_hit();
    clr();
    do_req(1, 0, 16'h0010, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 9) begin fails++; $display("FAIL miss_lat: got %0d expected 9", lat); end
    tests++; if (h !== 1'b0 || er !== 1'b0) begin fails++; $display("FAIL miss_flags: got hit=%b err=%b expected 0 0", h, er); end
    tests++; if (dout !== 16'hC3A8) begin fails++; $display("FAIL miss_data: got %h expected c3a8", dout); end
    tests++;
    if (rd_q.size() != 4 || wa_q.size() != 0) begin
      fails++; $display("FAIL miss_traffic: got rd=%0d wr=%0d expected 4 0", rd_q.size(), wa_q.size());
    end else if (rd_q[0] !== 16'h0010 || rd_q[1] !== 16'h0012 || rd_q[2] !== 16'h0014 || rd_q[3] !== 16'h0016) begin
      fails++; $display("FAIL miss_addrs: got %h %h %h %h expected 0010 0012 0014 0016", rd_q[0], rd_q[1], rd_q[2], rd_q[3]);
    end
    clr();
    do_req(1, 0, 16'h0010, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || h !== 1'b1) begin fails++; $display("FAIL hit_lat: got %0d hit=%b expected 2 1", lat, h); end
    tests++; if (dout !== 16'hC3A8 || rd_q.size() != 0) begin fails++; $display("FAIL hit_data: got %h rd=%0d expected c3a8 0", dout, rd_q.size()); end
  endtask

  task automatic test_write_hit();
    clr();
    do_req(0, 1, 16'h0012, 16'hBEEF, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || h !== 1'b1) begin fails++; $display("FAIL wr_hit: got lat=%0d hit=%b expected 2 1", lat, h); end
    do_req(1, 0, 16'h0012, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (dout !== 16'hBEEF || h !== 1'b1) begin fails++; $display("FAIL wr_readback: got %h hit=%b expected beef 1", dout, h); end
    tests++; if (rd_q.size() + wa_q.size() != 0) begin fails++; $display("FAIL wr_traffic: got %0d expected 0", rd_q.size() + wa_q.size()); end
  endtask

  task automatic test_dirty_miss();
    clr();
    do_req(1, 0, 16'h8010, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 13 || h !== 1'b0) begin fails++; $display("FAIL dirty_lat: got %0d hit=%b expected 13 0", lat, h); end
    tests++; if (dout !== 16'h83A8) begin fails++; $display("FAIL dirty_data: got %h expected 83a8", dout); end
    tests++;
    if (wa_q.size() != 4 || rd_q.size() != 4) begin
      fails++; $display("FAIL dirty_traffic: got wr=%0d rd=%0d expected 4 4", wa_q.size(), rd_q.size());
    end else if (wa_q[0] !== 16'h0010 || wa_q[1] !== 16'h0012 || wa_q[3] !== 16'h0016 ||
                 wd_q[0] !== 16'hC3A8 || wd_q[1] !== 16'hBEEF || rd_q[0] !== 16'h8010 || rd_q[3] !== 16'h8016) begin
      fails++; $display("FAIL dirty_wb: got wa0=%h wa1=%h wd0=%h wd1=%h rd0=%h expected 0010 0012 c3a8 beef 8010",
                        wa_q[0], wa_q[1], wd_q[0], wd_q[1], rd_q[0]);
    end
    clr();
    do_req(1, 0, 16'h0012, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 9 || dout !== 16'hBEEF || wa_q.size() != 0) begin
      fails++; $display("FAIL clean_refill: got lat=%0d %h wr=%0d expected 9 beef 0", lat, dout, wa_q.size());
    end
  endtask

  task automatic test_stall();
    clr();
    do_req(1, 0, 16'h0020, 0, 3, 3, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 12) begin fails++; $display("FAIL stall_lat: got %0d expected 12", lat); end
    tests++; if (hb !== 0) begin fails++; $display("FAIL stall_hold: got %0d bad cycles expected 0", hb); end
    tests++; if (dout !== 16'hC3B0 || rd_q.size() != 4) begin fails++; $display("FAIL stall_data: got %h rd=%0d expected c3b0 4", dout, rd_q.size()); end
  endtask

  task automatic test_error();
    clr();
    do_req(1, 1, 16'h0010, 16'h1111, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || er !== 1'b1 || h !== 1'b0) begin fails++; $display("FAIL err_rdwr: got lat=%0d err=%b hit=%b expected 2 1 0", lat, er, h); end
    do_req(1, 0, 16'h0011, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || er !== 1'b1) begin fails++; $display("FAIL err_align: got lat=%0d err=%b expected 2 1", lat, er); end
    tests++; if (rd_q.size() + wa_q.size() != 0) begin fails++; $display("FAIL err_traffic: got %0d expected 0", rd_q.size() + wa_q.size()); end
    do_req(1, 0, 16'h0012, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || dout !== 16'hBEEF || er !== 1'b0) begin fails++; $display("FAIL err_unchanged: got lat=%0d %h err=%b expected 2 beef 0", lat, dout, er); end
  endtask

  task automatic test_back_to_back();
    do_req(1, 0, 16'h0014, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || dout !== 16'hC3AA) begin fails++; $display("FAIL b2b_rd: got lat=%0d %h expected 2 c3aa", lat, dout); end
    do_req(0, 1, 16'h0016, 16'h5555, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || h !== 1'b1) begin fails++; $display("FAIL b2b_wr: got lat=%0d hit=%b expected 2 1", lat, h); end
    do_req(1, 0, 16'h0016, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || dout !== 16'h5555) begin fails++; $display("FAIL b2b_rdback: got lat=%0d %h expected 2 5555", lat, dout); end
  endtask

  task automatic test_reset_mid_fill();
    int nrd;
    clr();
    do_req(1, 0, 16'h0040, 0, 0, 0, 4, lat, dout, h, er, hb);
    nrd = rd_q.size();
    tests++; if (Stall !== 1'b0 || Done !== 1'b0) begin fails++; $display("FAIL rst_mid_state: got stall=%b done=%b expected 0 0", Stall, Done); end
    repeat (5) @(negedge clk);
    tests++; if (rd_q.size() != nrd || wa_q.size() != 0 || Done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_quiet: got rd=%0d wr=%0d done=%b expected %0d 0 0", rd_q.size(), wa_q.size(), Done, nrd);
    end
    clr();
    do_req(1, 0, 16'h0040, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 9 || dout !== 16'hC380 || rd_q.size() != 4) begin
      fails++; $display("FAIL rst_refill: got lat=%0d %h rd=%0d expected 9 c380 4", lat, dout, rd_q.size());
    end
    do_req(1, 0, 16'h0012, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 9 || h !== 1'b0 || dout !== 16'hBEEF) begin
      fails++; $display("FAIL rst_invalidated: got lat=%0d hit=%b %h expected 9 0 beef", lat, h, dout);
    end
  endtask

  task automatic test_no_alloc();
    sel = 1'b1;
    clr();
    do_req(0, 1, 16'h0030, 16'h1234, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 3 || h !== 1'b0) begin fails++; $display("FAIL wrna_lat: got %0d hit=%b expected 3 0", lat, h); end
    tests++;
    if (wa_q.size() != 1 || rd_q.size() != 0) begin
      fails++; $display("FAIL wrna_traffic: got wr=%0d rd=%0d expected 1 0", wa_q.size(), rd_q.size());
    end else if (wa_q[0] !== 16'h0030 || wd_q[0] !== 16'h1234) begin
      fails++; $display("FAIL wrna_write: got %h=%h expected 0030=1234", wa_q[0], wd_q[0]);
    end
    do_req(1, 0, 16'h0030, 0, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 9 || dout !== 16'h1234) begin fails++; $display("FAIL wrna_rd_miss: got lat=%0d %h expected 9 1234", lat, dout); end
    clr();
    do_req(0, 1, 16'h0030, 16'h4321, 0, 0, 0, lat, dout, h, er, hb);
    tests++; if (lat !== 2 || h !== 1'b1 || wa_q.size() != 0) begin
      fails++; $display("FAIL wrna_wr_hit: got lat=%0d hit=%b wr=%0d expected 2 1 0", lat, h, wa_q.size());
    end
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'hC3A0;
    @(negedge clk);
    test_reset();
    test_miss_hit();
    test_write_hit();
    test_dirty_miss();
    test_stall();
    test_error();
    test_back_to_back();
    test_reset_mid_fill();
    test_no_alloc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
